// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage register.
//   - pipe_state_t : occupancy FSM encoding (EMPTY / ONE / FULL)
//   - PIPE_DATA_W / PIPE_CTRL_W : default payload widths
//   - PERF_CNT_W / sat_inc : width and saturating increment for the
//     optional performance counters (PIPE_STAGE_PERF_EN)
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 16;
  localparam int PERF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: pair of 16-bit saturating event counters for the
// pipeline stage register. Only exists when PIPE_STAGE_PERF_EN is defined.
// Ports:
//   clk, reset            : clock, async active-low reset (clears counts)
//   i_inc_bubble          : one bubble was pushed this cycle
//   i_inc_backpressure    : head entry stalled this cycle
//   o_bubble_cnt          : bubble count, saturates at all-ones
//   o_backpressure_cnt    : stall-cycle count, saturates at all-ones
`ifdef PIPE_STAGE_PERF_EN
module perf_sat_counter
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_inc_bubble,
  input  logic                  i_inc_backpressure,
  output logic [PERF_CNT_W-1:0] o_bubble_cnt,
  output logic [PERF_CNT_W-1:0] o_backpressure_cnt
);

  logic [PERF_CNT_W-1:0] r_bubble_cnt;
  logic [PERF_CNT_W-1:0] r_backpressure_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble_cnt       <= '0;
      r_backpressure_cnt <= '0;
    end else begin
      if (i_inc_bubble)       r_bubble_cnt       <= sat_inc(r_bubble_cnt);
      if (i_inc_backpressure) r_backpressure_cnt <= sat_inc(r_backpressure_cnt);
    end
  end

  assign o_bubble_cnt       = r_bubble_cnt;
  assign o_backpressure_cnt = r_backpressure_cnt;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry (main + skid) pipeline stage register with
// hazard-bubble insertion and flush. Outputs always come from the main entry.
// Optional feature macro: PIPE_STAGE_PERF_EN adds perf_bubble_cnt and
// perf_backpressure_cnt (saturating 16-bit) via perf_sat_counter.
// Ports:
//   clk, reset             : clock (rising edge), async active-low reset
//   in_valid/in_ready      : upstream handshake
//   in_data/in_ctrl        : upstream datapath / control payload
//   in_bubble              : stall hazard, push a bubble instead of accepting
//   in_flush               : drop all held entries (redirect)
//   out_valid/out_ready    : downstream handshake
//   out_data/out_ctrl      : head entry payload
//   out_bubble             : head entry is an inserted bubble
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_bubble,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_bubble
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_bubble_cnt,
  output logic [PERF_CNT_W-1:0] perf_backpressure_cnt
`endif
);

  pipe_state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_main_data, r_skid_data, r_last_data;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
  logic              r_main_bubble, r_skid_bubble;

  logic              w_accept, w_bubble_push, w_push, w_pop;
  logic              w_load_main, w_load_skid, w_skid_to_main;
  logic [DATA_W-1:0] w_new_data;
  logic [CTRL_W-1:0] w_new_ctrl;

  assign in_ready      = (r_state != ST_FULL) & ~in_bubble & ~in_flush;
  assign w_accept      = in_valid & in_ready;
  assign w_bubble_push = in_bubble & ~in_flush & (r_state != ST_FULL);
  assign w_push        = w_accept | w_bubble_push;
  assign out_valid     = (r_state != ST_EMPTY);
  assign w_pop         = out_valid & out_ready;

  // A bubble replays the last accepted datapath payload so downstream
  // operand muxes see stable values, but carries no control.
  assign w_new_data = w_bubble_push ? r_last_data : in_data;
  assign w_new_ctrl = w_bubble_push ? '0 : in_ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (in_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt = ST_ONE;
            w_load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_load_main = 1'b1;
          end else if (w_push) begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt    = ST_ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_data   <= '0;
      r_main_ctrl   <= '0;
      r_main_bubble <= 1'b0;
      r_skid_data   <= '0;
      r_skid_ctrl   <= '0;
      r_skid_bubble <= 1'b0;
      r_last_data   <= '0;
    end else begin
      if (in_flush) begin
        // Payload data is held; only control and bubble flags are killed.
        r_main_ctrl   <= '0;
        r_main_bubble <= 1'b0;
        r_skid_ctrl   <= '0;
        r_skid_bubble <= 1'b0;
      end else begin
        if (w_load_main) begin
          r_main_data   <= w_new_data;
          r_main_ctrl   <= w_new_ctrl;
          r_main_bubble <= w_bubble_push;
        end else if (w_skid_to_main) begin
          r_main_data   <= r_skid_data;
          r_main_ctrl   <= r_skid_ctrl;
          r_main_bubble <= r_skid_bubble;
        end
        if (w_load_skid) begin
          r_skid_data   <= w_new_data;
          r_skid_ctrl   <= w_new_ctrl;
          r_skid_bubble <= w_bubble_push;
        end
      end
      if (w_accept) r_last_data <= in_data;
    end
  end

  assign out_data   = r_main_data;
  assign out_ctrl   = r_main_ctrl;
  assign out_bubble = r_main_bubble;

`ifdef PIPE_STAGE_PERF_EN
  perf_sat_counter u_perf (
    .clk                (clk),
    .reset              (reset),
    .i_inc_bubble       (w_bubble_push),
    .i_inc_backpressure (out_valid & ~out_ready),
    .o_bubble_cnt       (perf_bubble_cnt),
    .o_backpressure_cnt (perf_backpressure_cnt)
  );
`else
  // No performance counters in this build.
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: datapath payload width (operands, immediates, register indices).
REQ-002 SHALL have parameter CTRL_W, default 16: control payload width (alu op, write/load/store/branch/jump/panic bits); zeroed in bubbles.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port in_valid, input, 1 bit: upstream entry present.
REQ-006 SHALL have port in_ready, output, 1 bit: stage can accept an upstream entry.
REQ-007 SHALL have port in_data, input, DATA_W bits: upstream datapath payload.
REQ-008 SHALL have port in_ctrl, input, CTRL_W bits: upstream control payload.
REQ-009 SHALL have port in_bubble, input, 1 bit: hazard stall; insert a bubble instead of accepting.
REQ-010 SHALL have port in_flush, input, 1 bit: kill all held entries (branch/jump redirect).
REQ-011 SHALL have port out_valid, output, 1 bit: downstream entry present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream consumes the entry.
REQ-013 SHALL have port out_data, output, DATA_W bits: head entry datapath payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W bits: head entry control payload.
REQ-015 SHALL have port out_bubble, output, 1 bit: head entry is an inserted bubble.

Function
REQ-016 SHALL hold up to two entries (main + skid) in a 3-state FSM: EMPTY, ONE, FULL; outputs always driven from main.
REQ-017 SHALL drive in_ready = (state != FULL) & ~in_bubble & ~in_flush.
REQ-018 SHALL define push = (in_valid & in_ready) | (in_bubble & ~in_flush & state != FULL), and pop = out_valid & out_ready.
REQ-019 SHALL, on a bubble push, store ctrl = 0, out_bubble = 1, and data = last accepted in_data, consuming no upstream entry.
REQ-020 SHALL drive out_valid = (state != EMPTY), registered only; latency from push in EMPTY to out_valid is exactly 1 cycle.
REQ-021 SHALL transition EMPTY: push -> ONE; otherwise stay.
REQ-022 SHALL transition ONE: push&pop -> ONE (main replaced); push only -> FULL (new entry into skid); pop only -> EMPTY.
REQ-023 SHALL transition FULL: pop -> ONE (skid moves to main); no push is possible in FULL.
REQ-024 SHALL preserve entry order; no entry is dropped or duplicated except by flush.
REQ-025 SHALL give in_flush priority over push, pop and bubble: next state EMPTY, all ctrl and bubble flags zeroed, data held.
REQ-026 SHALL keep out_data/out_ctrl stable while out_valid & ~out_ready.

Reset
REQ-027 SHALL, while reset = 0, immediately force state EMPTY, out_valid 0, out_ctrl 0, out_bubble 0, out_data 0, skid cleared, last-data 0.
REQ-028 SHALL discard entries in flight when reset is asserted mid-operation, and accept new entries from the first clk edge after reset release.

Configuration
REQ-029 SHALL, when PIPE_STAGE_PERF_EN is defined, add outputs perf_bubble_cnt and perf_backpressure_cnt (16 bits each); these saturate at 0xFFFF and are cleared by reset.
REQ-030 SHALL increment perf_bubble_cnt per bubble push and perf_backpressure_cnt per cycle with out_valid & ~out_ready.
REQ-031 SHALL, without PIPE_STAGE_PERF_EN, have neither the counter ports nor the counter logic.

Structure
REQ-032 SHALL take the FSM state enum (EMPTY/ONE/FULL) and the default DATA_W/CTRL_W constants from the shared package pipe_pkg.
REQ-033 SHALL be implemented as a single module; the saturating counter pair, when enabled, is the optional sub-module perf_sat_counter.

Verification
REQ-034 SHALL cover streaming: in_valid=1 and out_ready=1 for 8 cycles with data 1..8 -> out_data 1..8 in order, 1-cycle latency, in_ready stays 1.
REQ-035 SHALL cover backpressure: out_ready=0 after entry A, push B -> state FULL, in_ready=0; out_ready=1 -> A then B, no loss.
REQ-036 SHALL cover bubble: in_bubble=1 for 1 cycle with in_ctrl=0xFFFF -> one entry with out_ctrl=0, out_bubble=1, data = previous entry; no upstream entry consumed.
REQ-037 SHALL cover flush in FULL with simultaneous in_valid=1 -> next cycle out_valid=0, out_ctrl=0, and the in_valid entry is not accepted.
REQ-038 SHALL cover reset: reset=0 mid-stream, asynchronous to clk -> outputs zero without a clk edge; first push after release appears 1 cycle later.
REQ-039 SHALL cover, with PIPE_STAGE_PERF_EN, 3 bubbles and 5 stall cycles -> counters read 3 and 5; preload to 0xFFFF -> counters hold at 0xFFFF.
